// File: rtl/dqn_bias_bank.sv
// Online/target bias register bank for one DQN layer: sequential saturating
// delta updates (one channel per cycle) and a single-cycle online->target copy.
module dqn_bias_bank #(
  parameter int          N_CH      = 4,
  parameter int          W         = 16,
  parameter int          SHIFT     = 0,
  parameter logic [3:0]  UPD_CODE  = 4'b0011,
  parameter logic [3:0]  SYNC_CODE = 4'b0101,
  localparam int         IDX_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ctrl,
  input  logic [3:0]        step,
  input  logic [N_CH*W-1:0] delta_in,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [W-1:0]      wr_data,
  input  logic              sat_clr,
  output logic [N_CH*W-1:0] bias_out,
  output logic [N_CH*W-1:0] tbias_out,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic [1:0]        dbg_state_o
);

  // Command handshake: a command is valid when step != 0 and ctrl equals
  // UPD_CODE or SYNC_CODE. It is taken on a rising edge only while busy is low;
  // commands and wr_en seen while busy are dropped, never queued. done pulses
  // for exactly one cycle after the pass completes, as busy falls.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SYNC   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [W-1:0]     MAX_VAL  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     bias_q   [N_CH];
  logic [W-1:0]     bias_d   [N_CH];
  logic [W-1:0]     tbias_q  [N_CH];
  logic [W-1:0]     tbias_d  [N_CH];
  logic [W-1:0]     shadow_q [N_CH];
  logic [W-1:0]     shadow_d [N_CH];
  logic             done_q, done_d;
  logic             sat_q, sat_d;

  logic             cmd_upd, cmd_sync;
  logic [W-1:0]     cur_val, scaled_val, upd_val;
  logic [W:0]       sum_ext;
  logic             ovf;

  assign cmd_upd  = (step != 4'd0) && (ctrl == UPD_CODE);
  assign cmd_sync = (step != 4'd0) && (ctrl == SYNC_CODE);

  // Sum in W+1 bits; overflow shows as disagreement of the top two bits.
  always_comb begin
    cur_val    = bias_q[idx_q];
    scaled_val = W'($signed(shadow_q[idx_q]) >>> SHIFT);
    sum_ext    = {cur_val[W-1], cur_val} + {scaled_val[W-1], scaled_val};
    ovf        = sum_ext[W] ^ sum_ext[W-1];
    upd_val    = sum_ext[W-1:0];
    if (ovf) begin
      upd_val = sum_ext[W] ? MIN_VAL : MAX_VAL;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bias_d   = bias_q;
    tbias_d  = tbias_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    sat_d    = sat_clr ? 1'b0 : sat_q;
    case (state_q)
      IDLE: begin
        if (cmd_upd) begin
          for (int i = 0; i < N_CH; i++) begin
            shadow_d[i] = delta_in[i*W +: W];
          end
          idx_d   = '0;
          state_d = UPDATE;
        end else if (cmd_sync) begin
          state_d = SYNC;
        end else if (wr_en && (int'(wr_idx) < N_CH)) begin
          bias_d[wr_idx] = wr_data;
        end
      end
      UPDATE: begin
        bias_d[idx_q] = upd_val;
        if (ovf) begin
          sat_d = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      SYNC: begin
        tbias_d = bias_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        bias_q[i]   <= '0;
        tbias_q[i]  <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      bias_q   <= bias_d;
      tbias_q  <= tbias_d;
      shadow_q <= shadow_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign bias_out[g*W +: W]  = bias_q[g];
    assign tbias_out[g*W +: W] = tbias_q[g];
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign sat_flag    = sat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dqn_bias_bank.sv
// Bench for dqn_bias_bank: two instances (SHIFT=0 and SHIFT=2) driven in
// lockstep and compared against an integer-arithmetic reference model.
module tb_dqn_bias_bank;

  localparam int N = 4;
  localparam int W = 16;
  localparam logic [3:0] UPD  = 4'b0011;
  localparam logic [3:0] SYNC = 4'b0101;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     ctrl, step;
  logic [N*W-1:0] delta_in;
  logic           wr_en;
  logic [1:0]     wr_idx;
  logic [W-1:0]   wr_data;
  logic           sat_clr;

  logic [N*W-1:0] bo [2];
  logic [N*W-1:0] to [2];
  logic           busy_w [2];
  logic           done_w [2];
  logic           sat_w  [2];
  logic [1:0]     st_w   [2];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_bias  [2][N];
  logic [W-1:0] m_tbias [2][N];
  logic         m_sat   [2];
  int           shf     [2] = '{0, 2};

  dqn_bias_bank #(.N_CH(N), .W(W), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .step(step), .delta_in(delta_in),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .sat_clr(sat_clr),
    .bias_out(bo[0]), .tbias_out(to[0]), .busy(busy_w[0]), .done(done_w[0]),
    .sat_flag(sat_w[0]), .dbg_state_o(st_w[0])
  );

  dqn_bias_bank #(.N_CH(N), .W(W), .SHIFT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .step(step), .delta_in(delta_in),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .sat_clr(sat_clr),
    .bias_out(bo[1]), .tbias_out(to[1]), .busy(busy_w[1]), .done(done_w[1]),
    .sat_flag(sat_w[1]), .dbg_state_o(st_w[1])
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference arithmetic: signed add of the shifted delta, clamped to W bits.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] d,
                                         input int sh);
    int av, dv, s;
    logic sat;
    av  = int'($signed(a));
    dv  = int'($signed(d)) >>> sh;
    s   = av + dv;
    sat = 1'b0;
    if (s > 32767) begin
      s = 32767;
      sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      sat = 1'b1;
    end
    return {sat, s[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic exp_busy, input logic exp_done, input string tag);
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        chk($sformatf("%s/u%0d/bias%0d", tag, k, ch), 32'(bo[k][ch*W +: W]), 32'(m_bias[k][ch]));
        chk($sformatf("%s/u%0d/tbias%0d", tag, k, ch), 32'(to[k][ch*W +: W]), 32'(m_tbias[k][ch]));
      end
      chk($sformatf("%s/u%0d/sat", tag, k), 32'(sat_w[k]), 32'(m_sat[k]));
      chk($sformatf("%s/u%0d/busy", tag, k), 32'(busy_w[k]), 32'(exp_busy));
      chk($sformatf("%s/u%0d/done", tag, k), 32'(done_w[k]), 32'(exp_done));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sat[k] = 1'b0;
      for (int ch = 0; ch < N; ch++) begin
        m_bias[k][ch]  = '0;
        m_tbias[k][ch] = '0;
      end
    end
  endtask

  task automatic idle_inputs();
    ctrl = 4'h0; step = 4'h0; wr_en = 1'b0; sat_clr = 1'b0;
  endtask

  // Driver tasks
  task automatic do_write(input int idx, input logic [W-1:0] data);
    @(negedge clk);
    ctrl = 4'h0; step = 4'($urandom_range(0, 15));
    wr_en = 1'b1; wr_idx = 2'(idx); wr_data = data;
    for (int k = 0; k < 2; k++) m_bias[k][idx] = data;
    @(negedge clk);
    idle_inputs();
    check_all(1'b0, 1'b0, "write");
  endtask

  task automatic do_clr();
    @(negedge clk);
    sat_clr = 1'b1;
    for (int k = 0; k < 2; k++) m_sat[k] = 1'b0;
    @(negedge clk);
    sat_clr = 1'b0;
    check_all(1'b0, 1'b0, "satclr");
  endtask

  // clr_mask bit c drives sat_clr for the c-th edge after the command is presented.
  task automatic do_update(input logic [N*W-1:0] d, input logic wr, input logic [N:0] clr_mask,
                           input logic junk, input string tag);
    logic [W-1:0] dl [N];
    logic [W:0]   r;
    @(negedge clk);
    ctrl = UPD; step = 4'($urandom_range(1, 15)); delta_in = d;
    wr_en = wr; wr_idx = 2'($urandom_range(0, N-1)); wr_data = W'($urandom);
    sat_clr = clr_mask[0];
    for (int ch = 0; ch < N; ch++) dl[ch] = d[ch*W +: W];
    for (int k = 0; k < 2; k++) if (clr_mask[0]) m_sat[k] = 1'b0;
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      check_all(1'b1, 1'b0, tag);
      ctrl = junk ? UPD : 4'h0;
      step = junk ? 4'hF : 4'h0;
      wr_en = junk; wr_idx = 2'($urandom_range(0, N-1)); wr_data = W'($urandom);
      delta_in = {$urandom, $urandom};
      sat_clr = clr_mask[c];
      for (int k = 0; k < 2; k++) begin
        r = sat_add(m_bias[k][c-1], dl[c-1], shf[k]);
        m_bias[k][c-1] = r[W-1:0];
        if (r[W]) m_sat[k] = 1'b1;
        else if (clr_mask[c]) m_sat[k] = 1'b0;
      end
    end
    @(negedge clk);
    check_all(1'b0, 1'b1, tag);
    idle_inputs();
    @(negedge clk);
    check_all(1'b0, 1'b0, tag);
  endtask

  task automatic do_sync(input string tag);
    @(negedge clk);
    ctrl = SYNC; step = 4'($urandom_range(1, 15));
    wr_en = 1'($urandom_range(0, 1)); wr_idx = 2'($urandom_range(0, N-1)); wr_data = W'($urandom);
    @(negedge clk);
    check_all(1'b1, 1'b0, tag);
    idle_inputs();
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < N; ch++) m_tbias[k][ch] = m_bias[k][ch];
    @(negedge clk);
    check_all(1'b0, 1'b1, tag);
    @(negedge clk);
    check_all(1'b0, 1'b0, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    delta_in = '0; wr_idx = '0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all(1'b0, 1'b0, "reset");

    // Load and update with one saturating channel.
    do_write(0, 16'h0010);
    do_write(1, 16'h0020);
    do_write(2, 16'hFFF0);
    do_write(3, 16'h7FF0);
    do_update({16'h0020, 16'h0020, 16'hFFFE, 16'h0001}, 1'b0, '0, 1'b0, "upd1");
    chk("upd1_ch0", 32'(bo[0][0*W +: W]), 32'h0011);
    chk("upd1_ch1", 32'(bo[0][1*W +: W]), 32'h001E);
    chk("upd1_ch2", 32'(bo[0][2*W +: W]), 32'h0010);
    chk("upd1_ch3", 32'(bo[0][3*W +: W]), 32'h7FFF);
    chk("upd1_sat", 32'(sat_w[0]), 32'h1);

    // step==0 ignores commands entirely; a plain write still lands.
    @(negedge clk);
    ctrl = UPD; step = 4'h0; delta_in = {$urandom, $urandom};
    @(negedge clk);
    idle_inputs();
    check_all(1'b0, 1'b0, "step0_upd");
    @(negedge clk);
    ctrl = SYNC; step = 4'h0; wr_en = 1'b1; wr_idx = 2'd2; wr_data = 16'h1234;
    for (int k = 0; k < 2; k++) m_bias[k][2] = 16'h1234;
    @(negedge clk);
    idle_inputs();
    check_all(1'b0, 1'b0, "step0_sync");

    // Command with wr_en: write dropped; busy-time commands ignored.
    do_update({16'h0100, 16'hFF00, 16'h0004, 16'h0008}, 1'b1, '0, 1'b1, "upd_wr_junk");

    // Sync, then update moves only the online copy.
    do_sync("sync1");
    do_update({16'h0003, 16'h0005, 16'h0007, 16'h0009}, 1'b0, '0, 1'b0, "upd_after_sync");

    // Scaling and clamp at the negative rail; sat_clr loses to a same-edge set.
    do_clr();
    do_write(0, 16'h0000);
    do_write(1, 16'h8000);
    do_update({16'h0000, 16'h0000, 16'h8000, 16'hFFFB}, 1'b0, 5'b00111, 1'b0, "scale");
    chk("scale_sh2_ch0", 32'(bo[1][0*W +: W]), 32'hFFFE);
    chk("scale_sh0_ch1", 32'(bo[0][1*W +: W]), 32'h8000);
    chk("scale_sh2_ch1", 32'(bo[1][1*W +: W]), 32'h8000);
    chk("scale_sat0", 32'(sat_w[0]), 32'h1);
    chk("scale_sat1", 32'(sat_w[1]), 32'h1);
    do_clr();

    // Randomized traffic.
    for (int it = 0; it < 10; it++) begin
      logic [N*W-1:0] d;
      do_write($urandom_range(0, N-1), W'($urandom));
      if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, N-1), W'($urandom_range(16'h7000, 16'h7FFF)));
      for (int ch = 0; ch < N; ch++) d[ch*W +: W] = W'($urandom);
      do_update(d, 1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 2) == 0) do_sync("rand_sync");
      if ($urandom_range(0, 3) == 0) do_clr();
    end

    // Asynchronous reset in the middle of an update pass (idx == 2).
    do_sync("pre_rst_sync");
    @(negedge clk);
    ctrl = UPD; step = 4'h1; delta_in = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(1'b0, 1'b0, "rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all(1'b0, 1'b0, "rst_release");
    do_update({16'h0001, 16'h0002, 16'h0003, 16'h0004}, 1'b0, '0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
